// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues line-sized Sysbus reads into a circular byte
// buffer and presents the decoder a byte window starting at o_fetch_pc.
module fetch_prefetch_buffer #(
    parameter int BUS_BYTES    = 8,
    parameter int LINE_BYTES   = 64,
    parameter int BUF_BYTES    = 128,
    parameter int WINDOW_BYTES = 15
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [63:0]                       i_entry,
    input  logic                              i_redirect_valid,
    input  logic [63:0]                       i_redirect_addr,
    output logic                              o_bus_reqcyc,
    output logic [63:0]                       o_bus_req,
    input  logic                              i_bus_reqack,
    input  logic                              i_bus_respcyc,
    input  logic [BUS_BYTES*8-1:0]            i_bus_resp,
    output logic                              o_bus_respack,
    output logic [WINDOW_BYTES*8-1:0]         o_win_bytes,
    output logic [$clog2(BUF_BYTES+1)-1:0]    o_win_avail,
    output logic                              o_win_valid,
    input  logic [$clog2(WINDOW_BYTES+1)-1:0] i_consume,
    output logic [63:0]                       o_fetch_pc
);
    localparam int BEATS = LINE_BYTES / BUS_BYTES;
    localparam int AW    = $clog2(BUF_BYTES + 1);
    localparam int PW    = $clog2(BUF_BYTES);
    localparam int LW    = $clog2(LINE_BYTES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [63:0] LINE_MASK = 64'(LINE_BYTES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACTIVE = 2'd3;

    logic [1:0]    r_state;
    logic          r_stale;
    logic          r_bus_reqcyc;
    logic [63:0]   r_bus_req;
    logic [63:0]   r_line_addr;
    logic [63:0]   r_fetch_pc;
    logic [LW-1:0] r_skip;
    logic [BW-1:0] r_beat;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [AW-1:0] r_avail;
    logic [7:0]    r_buf [BUF_BYTES];

    logic          w_beat;
    logic          w_line_end;
    logic          w_write;
    int            w_drop;
    logic [AW-1:0] w_keep;

    // Beats are always counted toward line end; data is kept only when not stale/redirected.
    always_comb begin
        w_beat     = i_reset && i_bus_respcyc && (r_state == S_WAIT || r_state == S_ACTIVE);
        w_line_end = w_beat && (r_beat == BW'(BEATS - 1));
        w_write    = w_beat && !r_stale && !i_redirect_valid;
        w_drop     = int'(r_skip) - int'(r_beat) * BUS_BYTES;
        if (w_drop < 0)
            w_drop = 0;
        else if (w_drop > BUS_BYTES)
            w_drop = BUS_BYTES;
        w_keep = w_write ? AW'(BUS_BYTES - w_drop) : '0;
    end

    // Kept bytes of a beat are a contiguous suffix, packed at the write pointer.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            for (int j = 0; j < BUS_BYTES; j++) begin
                if (j >= w_drop)
                    r_buf[r_wr_ptr + PW'(j - w_drop)] <= i_bus_resp[j*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_stale      <= 1'b0;
            r_bus_reqcyc <= 1'b0;
            r_bus_req    <= '0;
            r_beat       <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_avail      <= '0;
            r_fetch_pc   <= i_entry;
            r_line_addr  <= i_entry & ~LINE_MASK;
            r_skip       <= i_entry[LW-1:0];
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_redirect_valid && (AW'(BUF_BYTES) - r_avail) >= AW'(LINE_BYTES)) begin
                        r_state      <= S_REQ;
                        r_bus_reqcyc <= 1'b1;
                        r_bus_req    <= r_line_addr;
                    end
                end
                S_REQ: begin
                    if (i_bus_reqack) begin
                        r_state      <= S_WAIT;
                        r_bus_reqcyc <= 1'b0;
                    end
                end
                default: begin
                    if (w_beat) begin
                        r_state <= w_line_end ? S_IDLE : S_ACTIVE;
                        r_beat  <= w_line_end ? '0 : r_beat + 1'b1;
                    end
                end
            endcase

            if (w_line_end) begin
                r_stale <= 1'b0;
                if (!r_stale) begin
                    r_line_addr <= r_line_addr + 64'(LINE_BYTES);
                    r_skip      <= '0;
                end
            end

            // A redirect on the final beat needs no stale marking: that line is already over.
            if (i_redirect_valid) begin
                r_avail     <= '0;
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_fetch_pc  <= i_redirect_addr;
                r_line_addr <= i_redirect_addr & ~LINE_MASK;
                r_skip      <= i_redirect_addr[LW-1:0];
                if (r_state != S_IDLE && !w_line_end)
                    r_stale <= 1'b1;
            end else begin
                r_avail    <= r_avail + w_keep - AW'(i_consume);
                r_rd_ptr   <= r_rd_ptr + PW'(i_consume);
                r_wr_ptr   <= r_wr_ptr + PW'(w_keep);
                r_fetch_pc <= r_fetch_pc + 64'(i_consume);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && !i_redirect_valid)
            a_consume_le_avail: assert (AW'(i_consume) <= r_avail);
    end

    for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_win
        assign o_win_bytes[(WINDOW_BYTES-i)*8-1 -: 8] =
            (AW'(i) < r_avail) ? r_buf[r_rd_ptr + PW'(i)] : 8'h00;
    end

    assign o_bus_reqcyc  = r_bus_reqcyc;
    assign o_bus_req     = r_bus_req;
    assign o_bus_respack = i_bus_respcyc;
    assign o_win_avail   = r_avail;
    assign o_win_valid   = (r_avail >= AW'(WINDOW_BYTES));
    assign o_fetch_pc    = r_fetch_pc;

endmodule
